snn_spike_encoder: RTL

Rate-coded input encoder that sits directly upstream of `if_network`. It accepts one vector of `NUM_INPUTS` pixel intensities through a valid/ready handshake. It then drives `spike_out[NUM_INPUTS-1:0]` for exactly `NUM_STEPS` consecutive cycles, and each bit fires with probability proportional to its pixel value. Each input has its own 16-bit Galois LFSR, so a given seed and input sequence always produces a bit-exact, reproducible spike train.

---
 rtl/snn_encoder_pkg.sv | 34 +++
 rtl/snn_lfsr16.sv | 28 ++
 rtl/snn_spike_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/snn_encoder_pkg.sv
// Shared types and LFSR helpers for the rate-coded spike encoder.
// Galois LFSR taps x^16+x^14+x^13+x^11+1 and per-channel seed derivation.
package snn_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Rotate the base seed left by (idx mod 16); a nonzero base stays nonzero.
    function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int idx);
        logic [15:0] s;
        int          rot;
        s   = base;
        rot = idx % 32'sd16;
        for (int k = 32'sd0; k < 32'sd15; k++) begin
            if (k < rot) begin
                s = {s[14:0], s[15]};
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    // One right-shifting Galois step.
    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {1'b0, state[15:1]} ^ (state[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/snn_lfsr16.sv
// 16-bit Galois LFSR with enable; reloads SEED on synchronous reset.
module snn_lfsr16
    import snn_encoder_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_r;

    // LFSR state register: seed on reset, one step per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= SEED;
        end else if (en) begin
            q_r <= lfsr_next(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/snn_spike_encoder.sv
// Rate-coded spike encoder: accepts a pixel vector, then emits NUM_STEPS cycles
// of Bernoulli spikes per channel using independent 16-bit LFSRs.
module snn_spike_encoder
    import snn_encoder_pkg::*;
#(
    parameter int          NUM_INPUTS  = 1,
    parameter int          PIXEL_WIDTH = 8,
    parameter int          NUM_STEPS   = 100,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pixel_valid,
    output logic                              pixel_ready,
    input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_data,
    output logic [NUM_INPUTS-1:0]             spike_out,
    output logic                              spike_valid,
    output logic                              busy,
    output logic                              done
);

    localparam int                 CNT_W     = $clog2(NUM_STEPS + 1);
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(NUM_STEPS - 1);
    localparam logic [CNT_W-1:0]   STEP_ONE  = CNT_W'(32'd1);
    localparam logic [15:0]        PIX_MASK  = 16'((32'd1 << PIXEL_WIDTH) - 32'd1);

    enc_state_t                          state_r;
    enc_state_t                          next_state_s;
    logic [CNT_W-1:0]                    step_r;
    logic [NUM_INPUTS*PIXEL_WIDTH-1:0]   pixel_r;
    logic [NUM_INPUTS-1:0]               spike_cmp_s;
    logic [NUM_INPUTS-1:0]               spike_out_r;
    logic                                spike_valid_r;
    logic                                busy_r;
    logic                                done_r;
    logic                                accept_s;
    logic                                run_step_s;

    assign accept_s   = (state_r == IDLE) && pixel_valid;
    // Outputs and LFSR advance are keyed on the next state so that the
    // registered outputs line up with the state the FSM is in.
    assign run_step_s = (next_state_s == RUN);

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pixel_valid) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (step_r == LAST_STEP) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Step counter and pixel bank; pixels only change on an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r  <= {CNT_W{1'b0}};
            pixel_r <= {(NUM_INPUTS*PIXEL_WIDTH){1'b0}};
        end else if (accept_s) begin
            step_r  <= {CNT_W{1'b0}};
            pixel_r <= pixel_data;
        end else if (state_r == RUN) begin
            step_r  <= step_r + STEP_ONE;
            pixel_r <= pixel_r;
        end else begin
            step_r  <= step_r;
            pixel_r <= pixel_r;
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        logic [15:0]            lfsr_q_s;
        logic [PIXEL_WIDTH-1:0] pix_s;

        snn_lfsr16 #(
            .SEED (lfsr_seed(LFSR_SEED, i))
        ) u_lfsr (
            .clk (clk),
            .rst (rst),
            .en  (run_step_s),
            .q   (lfsr_q_s)
        );

        // The first timestep is produced on the handshake edge, before the bank is loaded.
        assign pix_s = accept_s ? pixel_data[i*PIXEL_WIDTH +: PIXEL_WIDTH]
                                : pixel_r[i*PIXEL_WIDTH +: PIXEL_WIDTH];

        assign spike_cmp_s[i] = (pix_s == {PIXEL_WIDTH{1'b1}}) ||
                                ((lfsr_q_s & PIX_MASK) < 16'(pix_s));
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_out_r   <= {NUM_INPUTS{1'b0}};
            spike_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            spike_out_r   <= run_step_s ? spike_cmp_s : {NUM_INPUTS{1'b0}};
            spike_valid_r <= run_step_s;
            busy_r        <= (next_state_s != IDLE);
            done_r        <= (next_state_s == DONE);
        end
    end

    assign pixel_ready = (state_r == IDLE);
    assign spike_out   = spike_out_r;
    assign spike_valid = spike_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule
